// File: rtl/data_mem_lsu.sv
// data_mem_lsu: word-organised data memory with byte-lane store formatting,
// sign/zero-extending loads, and a sticky first-fault capture register.
module data_mem_lsu #(
  parameter  int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_type,
  input  logic        fault_clr,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic [1:0]  fault_cause
);

  localparam int NUM_LANES = 4;

  logic [31:0] mem [DEPTH];

  logic [IDX_W-1:0]     idx;
  logic [1:0]           lane;
  logic                 oor, is_ld, is_st, legal, aligned, cand;
  logic                 do_wr;
  logic [NUM_LANES-1:0] be;
  logic [31:0]          wdat, rword;
  logic [7:0]           bsel;
  logic [15:0]          hsel;
  logic [1:0]           cause;

  assign idx   = addr[IDX_W+1:2];
  assign lane  = addr[1:0];
  assign oor   = (addr >> (IDX_W + 2)) != 32'd0;
  assign is_st = wr_en;
  // a simultaneous rd_en/wr_en is a store, so loads require wr_en low
  assign is_ld = rd_en && !wr_en;
  assign rword = mem[idx];

  // access decode: legality, alignment, fault candidate, store lane enables
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    be      = '0;
    wdat    = write_data;
    if (is_st)      legal = (mem_type == 3'b000) || (mem_type == 3'b001) || (mem_type == 3'b010);
    else if (is_ld) legal = (mem_type[1:0] != 2'b11) && !(mem_type[2] && mem_type[1]);
    case (mem_type[1:0])
      2'b01:   aligned = !addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    // illegal types never flag misalignment or fault
    misaligned = legal && !aligned;
    cand       = legal && (!aligned || oor);
    cause      = oor ? 2'b11 : (is_st ? 2'b10 : 2'b01);
    do_wr      = is_st && legal && aligned && !oor && !rst;
    case (mem_type[1:0])
      2'b00: begin
        be   = 4'b0001 << lane;
        wdat = {4{write_data[7:0]}};
      end
      2'b01: begin
        be   = addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{write_data[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // load formatting: lane select then sign- or zero-extend
  always_comb begin
    bsel      = rword[{lane, 3'b000} +: 8];
    hsel      = addr[1] ? rword[31:16] : rword[15:0];
    read_data = '0;
    if (is_ld && legal && aligned && !oor) begin
      case (mem_type)
        3'b000:  read_data = {{24{bsel[7]}}, bsel};
        3'b001:  read_data = {{16{hsel[15]}}, hsel};
        3'b010:  read_data = rword;
        3'b100:  read_data = {24'd0, bsel};
        3'b101:  read_data = {16'd0, hsel};
        default: read_data = '0;
      endcase
    end
  end

  // byte-lane store commit; array is intentionally not reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
    end
  end

  // sticky first-fault register; a new fault beats fault_clr in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_cause <= 2'b00;
    end else if (cand && (!fault_valid || fault_clr)) begin
      fault_valid <= 1'b1;
      fault_addr  <= addr;
      fault_cause <= cause;
    end else if (fault_clr) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_cause <= 2'b00;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: table-driven load/store vectors plus directed fault sequences.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  mem_type = '0;
  logic        fault_clr = 1'b0;
  logic [31:0] read_data;
  logic        misaligned;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  data_mem_lsu #(.DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .rd_en(rd_en), .wr_en(wr_en), .mem_type(mem_type), .fault_clr(fault_clr),
    .read_data(read_data), .misaligned(misaligned), .fault_valid(fault_valid),
    .fault_addr(fault_addr), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rd;
    logic        wr;
    logic [2:0]  mt;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    rd_en = r; wr_en = w; mem_type = t; addr = a; write_data = d;
    #1;
  endtask

  // advance past one rising edge; sample at the following falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic chk_fault(input string nm, input logic v, input logic [31:0] a, input logic [1:0] c);
    chk({nm, "_fv"}, {31'd0, fault_valid}, {31'd0, v});
    chk({nm, "_fa"}, fault_addr, a);
    chk({nm, "_fc"}, {30'd0, fault_cause}, {30'd0, c});
  endtask

  initial begin
    tbl.push_back('{"sw_10",      0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0});
    tbl.push_back('{"lw_10",      1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0});
    tbl.push_back('{"lb_13",      1, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0});
    tbl.push_back('{"lbu_10",     1, 0, 3'b100, 32'h10, 32'h0,        32'h000000EF, 0});
    tbl.push_back('{"lh_12",      1, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0});
    tbl.push_back('{"lhu_10",     1, 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0});
    tbl.push_back('{"sb_11",      0, 1, 3'b000, 32'h11, 32'h123456AA, 32'h0,        0});
    tbl.push_back('{"lw_after_sb",1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADAAEF, 0});
    tbl.push_back('{"sh_12",      0, 1, 3'b001, 32'h12, 32'h0000CAFE, 32'h0,        0});
    tbl.push_back('{"lw_after_sh",1, 0, 3'b010, 32'h10, 32'h0,        32'hCAFEAAEF, 0});
    tbl.push_back('{"lb_11",      1, 0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAA, 0});
    tbl.push_back('{"lbu_13",     1, 0, 3'b100, 32'h13, 32'h0,        32'h000000CA, 0});
    tbl.push_back('{"lhu_12",     1, 0, 3'b101, 32'h12, 32'h0,        32'h0000CAFE, 0});
    tbl.push_back('{"ld_illegal", 1, 0, 3'b011, 32'h10, 32'h0,        32'h0,        0});
    tbl.push_back('{"no_rd_en",   0, 0, 3'b010, 32'h10, 32'h0,        32'h0,        0});
    tbl.push_back('{"st_illegal", 0, 1, 3'b100, 32'h10, 32'h0,        32'h0,        0});
    tbl.push_back('{"lw_unchg",   1, 0, 3'b010, 32'h10, 32'h0,        32'hCAFEAAEF, 0});

    // reset state
    rst = 1'b1; idle();
    tick(); tick();
    rst = 1'b0;
    chk_fault("reset", 1'b0, 32'h0, 2'b00);

    // formatted loads and partial stores
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].mt, tbl[i].a, tbl[i].d);
      chk({tbl[i].nm, "_rd"}, read_data, tbl[i].exp_rd);
      chk({tbl[i].nm, "_mis"}, {31'd0, misaligned}, {31'd0, tbl[i].exp_mis});
      tick();
    end
    idle();
    chk("no_fault_after_table", {31'd0, fault_valid}, 32'd0);

    // misaligned load captured, later misaligned store ignored, then clear
    drive(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    chk("mis_lw_rd", read_data, 32'h0);
    chk("mis_lw_mis", {31'd0, misaligned}, 32'd1);
    tick();
    chk_fault("mis_lw", 1'b1, 32'h6, 2'b01);
    drive(1'b0, 1'b1, 3'b001, 32'h13, 32'h0000FFFF);
    chk("mis_sh_mis", {31'd0, misaligned}, 32'd1);
    tick();
    chk_fault("mis_sh_held", 1'b1, 32'h6, 2'b01);
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("mis_sh_nowrite", read_data, 32'hCAFEAAEF);
    idle(); fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk_fault("clr", 1'b0, 32'h0, 2'b00);

    // out of range store
    drive(1'b0, 1'b1, 3'b010, 32'h0, 32'hA5A5A5A5);
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h1000, 32'h11111111);
    chk("oor_mis", {31'd0, misaligned}, 32'd0);
    tick();
    chk_fault("oor", 1'b1, 32'h1000, 2'b11);
    drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("oor_nowrite", read_data, 32'hA5A5A5A5);
    drive(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
    chk("oor_ld_rd", read_data, 32'h0);

    // capture wins over fault_clr in the same cycle
    drive(1'b1, 1'b0, 3'b010, 32'h2, 32'h0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk_fault("clr_vs_cap", 1'b1, 32'h2, 2'b01);

    // rd_en+wr_en is a store
    drive(1'b1, 1'b1, 3'b010, 32'h20, 32'h55);
    chk("rdwr_rd", read_data, 32'h0);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    chk("rdwr_lw", read_data, 32'h00000055);

    // reset blocks a store and clears a pending fault
    drive(1'b0, 1'b1, 3'b010, 32'h24, 32'h66);
    tick();
    drive(1'b0, 1'b1, 3'b010, 32'h24, 32'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_fault("rst_mid", 1'b0, 32'h0, 2'b00);
    drive(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
    chk("rst_nowrite", read_data, 32'h00000066);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Data memory with integrated load/store formatting for the single-cycle processor. It sits between the ALU, which supplies the effective address, and the writeback multiplexer, which consumes `read_data`. Stores are byte-lane formatted and committed on the clock edge; loads are read combinationally, then lane-selected and sign- or zero-extended. Misaligned and out-of-range accesses are detected, suppressed, and logged in a sticky fault register.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; must be a power of two. `IDX_W = $clog2(DEPTH)`.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `addr`  in  32  — byte address (ALU result).
- `write_data`  in  32  — store data (rs2 value).
- `rd_en`  in  1  — load request.
- `wr_en`  in  1  — store request.
- `mem_type`  in  3  — funct3 encoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `fault_clr`  in  1  — clears the sticky fault register.
- `read_data`  out  32  — formatted load result, to the writeback mux.
- `misaligned`  out  1  — combinational flag for the current misaligned access.
- `fault_valid`  out  1  — sticky fault flag.
- `fault_addr`  out  32  — address of the first captured fault.
- `fault_cause`  out  2  — 01 misaligned load, 10 misaligned store, 11 out of range.

## Operation
- **Addressing:** word index = `addr[IDX_W+1:2]`; lane = `addr[1:0]`. The access is out of range when any of `addr[31:IDX_W+2]` is nonzero.
- **Alignment rules:** half-word requires `addr[0]==0`; word requires `addr[1:0]==0`; byte accesses are always aligned.
- **Stores** (`wr_en`, legal, aligned, in range) use per-lane byte enables:
  - SB writes `write_data[7:0]` into lane `addr[1:0]`.
  - SH writes `write_data[15:0]` into lanes {1,0} when `addr[1]==0`, otherwise lanes {3,2}.
  - SW writes all four lanes.
  - Lanes not enabled keep their previous contents.
- **Loads** (`rd_en`, no `wr_en`, legal, aligned, in range) select the addressed byte or half-word from the word:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW returns the whole word.
- **`read_data` is 0** when:
  - `rd_en` is 0,
  - `wr_en` is 1,
  - `mem_type` is illegal,
  - the access is misaligned, or
  - the access is out of range.
- **Illegal `mem_type`** (011, 110, 111, and 100/101 used with `wr_en`): no write, `read_data` 0, no fault.
- **`rd_en` and `wr_en` both high:** treated as a store; `read_data` is 0.
- **Misaligned or out-of-range access:**
  - Write suppressed, `read_data` 0.
  - `misaligned` = 1 only for the misaligned case; out-of-range does not assert it.
  - Fault is a candidate for capture. Out-of-range takes precedence over misaligned for the cause code.
- **Fault capture:** on the clock edge, with `fault_valid==0` and a candidate present, load `fault_valid`=1, `fault_addr`=`addr`, and `fault_cause`. Later faults are ignored until cleared (first fault is held).
- **`fault_clr`:** clears `fault_valid`, `fault_addr`, and `fault_cause` at the edge. If a new candidate occurs in the same cycle as `fault_clr`, the new fault is captured (capture wins).
- **Reset values:** `fault_valid` 0, `fault_addr` 0, `fault_cause` 00. The memory array is not cleared. `read_data` and `misaligned` are combinational.

## Timing
- Load latency is 0 cycles: `read_data` is combinational from `addr`, `mem_type`, `rd_en`, and array contents.
- Store commit is 1 cycle: the array updates at the rising edge where `wr_en` qualifies.
- **Same-address read during write** (a separate port/cycle view): reads in the store cycle see the old data; the new data is visible from the next cycle.
- `rst` high blocks stores in that cycle and clears the fault registers; it overrides fault capture and `fault_clr`.
- `fault_*` outputs change only at rising edges.

## Test plan
1. **Formatted loads.** After `rst`, SW 0xDEADBEEF at 0x10, then:
   - LW 0x10 → 0xDEADBEEF
   - LB 0x13 → 0xFFFFFFDE
   - LBU 0x10 → 0x000000EF
   - LH 0x12 → 0xFFFFDEAD
   - LHU 0x10 → 0x0000BEEF
2. **Partial stores.** SB 0x123456AA at 0x11 → LW 0x10 = 0xDEADAAEF. SH 0x0000CAFE at 0x12 → LW 0x10 = 0xCAFEAAEF.
3. **Misaligned load, then misaligned store.**
   - LW 0x06 → `read_data` 0, `misaligned` 1.
   - Next cycle: `fault_valid` 1, `fault_addr` 0x6, `fault_cause` 01.
   - SH 0x0000FFFF at 0x13 → `misaligned` 1, memory unchanged, `fault_addr` still 0x6.
   - Pulse `fault_clr` → all fault outputs 0.
4. **Out of range** (`DEPTH`=1024). SW 0x11111111 at 0x1000 → no write (LW 0x0 unchanged), `fault_cause` 11, `fault_addr` 0x1000, `misaligned` 0.
5. **Simultaneous events.**
   - `fault_clr` with a misaligned LW at 0x02 in the same cycle → `fault_valid` 1, `fault_addr` 0x2.
   - `rd_en`+`wr_en` SW 0x55 at 0x20 → `read_data` 0; next cycle LW 0x20 = 0x00000055.
6. **Reset mid-operation.** `rst` high with SW 0x77 at 0x24 and a pending fault → LW 0x24 unchanged afterwards, `fault_valid` 0, `fault_addr` 0.
